// File: rtl/interp_channel_scheduler.sv
// interp_channel_scheduler
// Shares one zero-stuffing interpolator between NUM_CH sample channels.
// Samples are admitted round-robin, at most one every INTERP_FACTOR enabled
// cycles, so the interpolator FIFO never builds a backlog. The channel id of
// each admitted sample is pushed into a small tag queue and used to relabel
// the interpolator output stream, INTERP_FACTOR outputs per admitted sample.
module interp_channel_scheduler #(
  parameter  int DATA_WIDTH    = 16,
  parameter  int NUM_CH        = 4,
  parameter  int INTERP_FACTOR = 3,
  parameter  int TAG_DEPTH     = 4,
  localparam int CH_W          = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_in_data,
  input  logic [NUM_CH-1:0]            ch_in_valid,
  output logic [NUM_CH-1:0]            ch_in_ready,
  output logic                         inter_clk_enable,
  output logic [DATA_WIDTH-1:0]        sched_data,
  output logic                         sched_valid,
  output logic [CH_W-1:0]              sched_ch,
  input  logic [DATA_WIDTH-1:0]        inter_out,
  input  logic                         inter_out_valid,
  output logic [DATA_WIDTH-1:0]        tagged_data,
  output logic                         tagged_valid,
  output logic [CH_W-1:0]              tagged_ch,
  output logic                         tagged_first,
  output logic                         tag_err
);

  localparam int SLOT_W = $clog2(INTERP_FACTOR);
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(INTERP_FACTOR - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(TAG_DEPTH);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

  // Arbitration / issue state
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SLOT_W-1:0]     slot_cnt_q, slot_cnt_d;
  logic [DATA_WIDTH-1:0] sched_data_q, sched_data_d;
  logic                  sched_valid_q, sched_valid_d;
  logic [CH_W-1:0]       sched_ch_q, sched_ch_d;

  // Tag queue
  logic [CH_W-1:0]       tag_mem_q [TAG_DEPTH];
  logic [CH_W-1:0]       tag_mem_d [TAG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      tag_cnt_q, tag_cnt_d;
  logic [SLOT_W-1:0]     out_phase_q, out_phase_d;

  // Relabelled output
  logic [DATA_WIDTH-1:0] tagged_data_q, tagged_data_d;
  logic                  tagged_valid_q, tagged_valid_d;
  logic [CH_W-1:0]       tagged_ch_q, tagged_ch_d;
  logic                  tagged_first_q, tagged_first_d;
  logic                  tag_err_q, tag_err_d;

  logic                  grant_found;
  logic [CH_W-1:0]       grant_id;
  logic                  issue;
  logic                  tag_full;
  logic                  tag_empty;
  logic                  out_adv;
  logic                  tag_pop;
  logic [CH_W-1:0]       tag_head;

  assign tag_full  = (tag_cnt_q == CNT_FULL);
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_head  = tag_mem_q[rd_ptr_q];

  // Round-robin search: first valid channel at or after rr_ptr, with wrap.
  always_comb begin : arb_comb
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CH;
      if (!grant_found && ch_in_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = CH_W'(idx);
      end
    end
  end

  assign issue       = enable && (slot_cnt_q == '0) && grant_found && !tag_full;
  assign ch_in_ready = issue ? (NUM_CH'(1) << grant_id) : '0;

  // Slot pacing, round-robin pointer and the registered issue port.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    slot_cnt_d    = slot_cnt_q;
    sched_data_d  = sched_data_q;
    sched_ch_d    = sched_ch_q;
    sched_valid_d = 1'b0;
    if (enable) begin
      if (issue) begin
        slot_cnt_d    = SLOT_W'(1);
        rr_ptr_d      = (grant_id == CH_LAST) ? '0 : grant_id + CH_W'(1);
        sched_data_d  = ch_in_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        sched_ch_d    = grant_id;
        sched_valid_d = 1'b1;
      end else if (slot_cnt_q != '0) begin
        slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SLOT_W'(1);
      end
    end
  end

  // Tag queue bookkeeping; an output on an empty queue neither pops nor
  // advances the phase, so a stray pulse cannot desynchronise later samples.
  always_comb begin
    out_adv   = enable && inter_out_valid && !tag_empty;
    tag_pop   = out_adv && (out_phase_q == SLOT_LAST);
    tag_mem_d = tag_mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_cnt_d = tag_cnt_q;
    out_phase_d = out_phase_q;
    if (issue) begin
      tag_mem_d[wr_ptr_q] = grant_id;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (tag_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (issue && !tag_pop) begin
      tag_cnt_d = tag_cnt_q + CNT_W'(1);
    end else if (!issue && tag_pop) begin
      tag_cnt_d = tag_cnt_q - CNT_W'(1);
    end
    if (out_adv) begin
      out_phase_d = (out_phase_q == SLOT_LAST) ? '0 : out_phase_q + SLOT_W'(1);
    end
  end

  // Output relabel, one cycle behind the interpolator output.
  always_comb begin
    tagged_data_d  = tagged_data_q;
    tagged_valid_d = tagged_valid_q;
    tagged_ch_d    = tagged_ch_q;
    tagged_first_d = tagged_first_q;
    tag_err_d      = tag_err_q;
    if (enable) begin
      tagged_data_d  = inter_out;
      tagged_valid_d = inter_out_valid;
      tagged_ch_d    = tag_empty ? '0 : tag_head;
      tagged_first_d = inter_out_valid && (out_phase_q == '0);
      if (inter_out_valid && tag_empty) begin
        tag_err_d = 1'b1;
      end
    end
  end

  // State register; reset discards any in-flight tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      slot_cnt_q     <= '0;
      sched_data_q   <= '0;
      sched_valid_q  <= 1'b0;
      sched_ch_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      tag_cnt_q      <= '0;
      out_phase_q    <= '0;
      tagged_data_q  <= '0;
      tagged_valid_q <= 1'b0;
      tagged_ch_q    <= '0;
      tagged_first_q <= 1'b0;
      tag_err_q      <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_mem_q[i] <= '0;
      end
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      slot_cnt_q     <= slot_cnt_d;
      sched_data_q   <= sched_data_d;
      sched_valid_q  <= sched_valid_d;
      sched_ch_q     <= sched_ch_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      tag_cnt_q      <= tag_cnt_d;
      out_phase_q    <= out_phase_d;
      tagged_data_q  <= tagged_data_d;
      tagged_valid_q <= tagged_valid_d;
      tagged_ch_q    <= tagged_ch_d;
      tagged_first_q <= tagged_first_d;
      tag_err_q      <= tag_err_d;
      tag_mem_q      <= tag_mem_d;
    end
  end

  assign inter_clk_enable = enable;
  assign sched_data       = sched_data_q;
  assign sched_valid      = sched_valid_q;
  assign sched_ch         = sched_ch_q;
  assign tagged_data      = tagged_data_q;
  assign tagged_valid     = tagged_valid_q;
  assign tagged_ch        = tagged_ch_q;
  assign tagged_first     = tagged_first_q;
  assign tag_err          = tag_err_q;

endmodule

// File: tb/tb_interp_channel_scheduler.sv
// Bench for interp_channel_scheduler. The bench plays both the channel
// sources and the interpolator (zero-stuffing, factor 3). A reference model
// predicts grants; expected issues and relabelled outputs are queued when
// stimulus is driven and compared when the DUT presents them.
module tb_interp_channel_scheduler;
  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int IF  = 3;
  localparam int TD  = 4;
  localparam int CW  = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] ch;
    logic          f;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic [NCH*DW-1:0] ch_in_data;
  logic [NCH-1:0]    ch_in_valid;
  logic [NCH-1:0]    ch_in_ready;
  logic              inter_clk_enable;
  logic [DW-1:0]     sched_data;
  logic              sched_valid;
  logic [CW-1:0]     sched_ch;
  logic [DW-1:0]     inter_out;
  logic              inter_out_valid;
  logic [DW-1:0]     tagged_data;
  logic              tagged_valid;
  logic [CW-1:0]     tagged_ch;
  logic              tagged_first;
  logic              tag_err;

  interp_channel_scheduler #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .INTERP_FACTOR(IF), .TAG_DEPTH(TD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ch_in_data(ch_in_data), .ch_in_valid(ch_in_valid), .ch_in_ready(ch_in_ready),
    .inter_clk_enable(inter_clk_enable),
    .sched_data(sched_data), .sched_valid(sched_valid), .sched_ch(sched_ch),
    .inter_out(inter_out), .inter_out_valid(inter_out_valid),
    .tagged_data(tagged_data), .tagged_valid(tagged_valid), .tagged_ch(tagged_ch),
    .tagged_first(tagged_first), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  ent_t          sexp[$];
  ent_t          texp[$];
  ent_t          ifq[$];
  logic [CW-1:0] mtag[$];
  int            m_rr, m_slot, m_phase;
  logic          m_err;
  logic [DW-1:0] dval [NCH];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    sexp.delete(); texp.delete(); ifq.delete(); mtag.delete();
    m_rr = 0; m_slot = 0; m_phase = 0; m_err = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check grant, predict, check after posedge.
  task automatic cycle(input logic en, input logic [NCH-1:0] vm, input logic st, input logic spur);
    logic [NCH-1:0] exp_rdy;
    logic           iss;
    int             g, idx;
    ent_t           e, n;
    enable      = en;
    ch_in_valid = vm;
    for (int i = 0; i < NCH; i++) ch_in_data[i*DW +: DW] = dval[i];
    if (spur) begin
      inter_out_valid = 1'b1;
      inter_out       = 16'h7abc;
    end else if (en && !st && ifq.size() > 0) begin
      e               = ifq.pop_front();
      inter_out_valid = 1'b1;
      inter_out       = e.d;
    end else begin
      inter_out_valid = 1'b0;
      inter_out       = DW'($urandom);
    end
    #1;
    iss = 1'b0; g = 0; exp_rdy = '0;
    if (en && m_slot == 0 && mtag.size() < TD) begin
      for (int k = 0; k < NCH; k++) begin
        idx = (m_rr + k) % NCH;
        if (!iss && vm[idx]) begin iss = 1'b1; g = idx; end
      end
    end
    if (iss) exp_rdy[g] = 1'b1;
    chk("ready", ch_in_ready, exp_rdy);
    chk("iclk_en", inter_clk_enable, en);
    if (en && inter_out_valid) begin
      if (mtag.size() == 0) begin
        m_err = 1'b1;
        n.d = inter_out; n.ch = '0; n.f = (m_phase == 0);
        texp.push_back(n);
      end else begin
        n.d = inter_out; n.ch = e.ch; n.f = e.f;
        texp.push_back(n);
        if (m_phase == IF - 1) begin
          m_phase = 0;
          void'(mtag.pop_front());
        end else m_phase++;
      end
    end
    if (en) begin
      if (iss) begin
        n.d = dval[g]; n.ch = CW'(g); n.f = 1'b1;
        sexp.push_back(n);
        mtag.push_back(CW'(g));
        m_rr   = (g + 1) % NCH;
        m_slot = 1;
        dval[g] = dval[g] + 16'h0011;
      end else if (m_slot != 0) begin
        m_slot = (m_slot == IF - 1) ? 0 : m_slot + 1;
      end
    end
    @(posedge clk);
    #1;
    if (sexp.size() > 0) begin
      e = sexp.pop_front();
      chk("sched_valid", sched_valid, 1);
      chk("sched_data", sched_data, e.d);
      chk("sched_ch", sched_ch, e.ch);
      n.d = e.d; n.ch = e.ch; n.f = 1'b1;
      ifq.push_back(n);
      for (int k = 1; k < IF; k++) begin
        n.d = '0; n.f = 1'b0;
        ifq.push_back(n);
      end
    end else begin
      chk("sched_idle", sched_valid, 0);
    end
    if (en) begin
      if (texp.size() > 0) begin
        e = texp.pop_front();
        chk("tagged_valid", tagged_valid, 1);
        chk("tagged_data", tagged_data, e.d);
        chk("tagged_ch", tagged_ch, e.ch);
        chk("tagged_first", tagged_first, e.f);
      end else begin
        chk("tagged_idle", tagged_valid, 0);
      end
    end
    chk("tag_err", tag_err, m_err);
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic en, input logic [NCH-1:0] vm, input logic st);
    repeat (n) cycle(en, vm, st, 1'b0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((mtag.size() > 0 || ifq.size() > 0 || sexp.size() > 0) && g < 100) begin
      cycle(1'b1, '0, 1'b0, 1'b0);
      g++;
    end
    chk("drain", mtag.size() + ifq.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ready"}, ch_in_ready, 0);
    chk({tag, "_sv"}, sched_valid, 0);
    chk({tag, "_sd"}, sched_data, 0);
    chk({tag, "_sc"}, sched_ch, 0);
    chk({tag, "_tv"}, tagged_valid, 0);
    chk({tag, "_td"}, tagged_data, 0);
    chk({tag, "_tc"}, tagged_ch, 0);
    chk({tag, "_tf"}, tagged_first, 0);
    chk({tag, "_err"}, tag_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst_n = 1'b0; enable = 1'b0; ch_in_valid = '0; ch_in_data = '0;
    inter_out = '0; inter_out_valid = 1'b0;
    for (int i = 0; i < NCH; i++) dval[i] = DW'(16'h1000 * (i + 1));
    model_clear();
    #1;
    check_zero("reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Single channel: ch2 with 0x0100
    dval[2] = 16'h0100;
    cycle(1'b1, 4'b0100, 1'b0, 1'b0);
    drain();

    // All channels continuously valid
    run(16, 1'b1, '1, 1'b0);
    drain();

    // Output stall fills the tag queue, then releases
    run(16, 1'b1, '1, 1'b1);
    chk("stall_full", mtag.size(), TD);
    run(12, 1'b1, '1, 1'b0);
    drain();

    // Enable drop in the middle of a slot
    guard = 0;
    while (m_slot != 1 && guard < 20) begin
      cycle(1'b1, '1, 1'b0, 1'b0);
      guard++;
    end
    chk("reach_slot1", guard < 20, 1);
    run(5, 1'b0, '1, 1'b0);
    run(10, 1'b1, '1, 1'b0);
    drain();

    // Spurious interpolator output on an empty queue, then a normal sample
    cycle(1'b1, '0, 1'b0, 1'b1);
    run(3, 1'b1, '0, 1'b0);
    cycle(1'b1, 4'b0010, 1'b0, 1'b0);
    drain();

    // Asynchronous reset with two tags queued
    guard = 0;
    while (mtag.size() < 2 && guard < 20) begin
      cycle(1'b1, '1, 1'b1, 1'b0);
      guard++;
    end
    chk("two_tags", mtag.size(), 2);
    #2;
    rst_n = 1'b0; enable = 1'b0; ch_in_valid = '0; inter_out_valid = 1'b0;
    #1;
    check_zero("midrst");
    chk("midrst_iclk", inter_clk_enable, 0);
    model_clear();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, '0, 1'b0, 1'b1);
    run(6, 1'b1, '1, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
